// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for data-memory responders.
// Word/byte-lane widths, FSM encodings, access legality check.
package dmem_responder_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Misaligned, below base, or past the end of a 2**aw word window.
  function automatic logic acc_err(
    input logic [31:0] addr,
    input logic [31:0] base,
    input int unsigned aw
  );
    logic [32:0] off;
    off = {1'b0, addr} - {1'b0, base};
    return (addr[1:0] != 2'b00) || off[32] ||
           ((off[31:0] >> (aw + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Valid/ready request and response channels
// between the core's data port and a responder.
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_addr;
  logic              req_we;
  logic [BE_W-1:0]   req_be;
  logic [WORD_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [WORD_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_addr, req_we,
    output req_be, req_wdata, resp_ready,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we,
    input  req_be, req_wdata, resp_ready,
    output req_ready, resp_valid,
    output resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_responder_array.sv
// Word storage: byte-enable sync write,
// sync clear on reset, async read by index.
module dmem_responder_array
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [BE_W-1:0]   be,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < BE_W; b++)
        if (be[b])
          mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one transaction in flight,
// programmable wait states, commit on entry to RESP.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          ADDR_W      = 10,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);

  localparam bit NO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_INIT =
    NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic [31:0]       addr_q;
  logic              we_q;
  logic [BE_W-1:0]   be_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] rdata_q;
  logic              err_q;

  logic              accept;
  logic              go_resp;
  logic [31:0]       c_addr;
  logic              c_we;
  logic [BE_W-1:0]   c_be;
  logic [WORD_W-1:0] c_wdata;
  logic              c_err;
  logic [ADDR_W-1:0] c_idx;
  logic              arr_we;
  logic [WORD_W-1:0] arr_rdata;

  assign bus.req_ready = (state == ST_IDLE) && !reset;
  assign accept = bus.req_valid && bus.req_ready;

  // Zero wait states commit on the accept edge,
  // so the live request is used instead of the latch.
  assign c_addr  = NO_WAIT ? bus.req_addr  : addr_q;
  assign c_we    = NO_WAIT ? bus.req_we    : we_q;
  assign c_be    = NO_WAIT ? bus.req_be    : be_q;
  assign c_wdata = NO_WAIT ? bus.req_wdata : wdata_q;

  assign go_resp = NO_WAIT ?
    ((state == ST_IDLE) && accept) :
    ((state == ST_WAIT) && (cnt == 4'd0));

  assign c_err  = acc_err(c_addr, BASE_ADDR, ADDR_W);
  assign c_idx  = ADDR_W'((c_addr - BASE_ADDR) >> 2);
  assign arr_we = go_resp && c_we && !c_err;

  dmem_responder_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk  (clk),
    .reset(reset),
    .we   (arr_we),
    .idx  (c_idx),
    .be   (c_be),
    .wdata(c_wdata),
    .rdata(arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            addr_q  <= bus.req_addr;
            we_q    <= bus.req_we;
            be_q    <= bus.req_be;
            wdata_q <= bus.req_wdata;
            cnt     <= CNT_INIT;
            state   <= NO_WAIT ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) state <= ST_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        ST_RESP: begin
          if (bus.resp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      if (go_resp) begin
        rdata_q <= (c_we || c_err) ? '0 : arr_rdata;
        err_q   <= c_err;
      end
    end
  end

  assign bus.resp_valid = (state == ST_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: two responders (2 and 0 wait
// states), random traffic vs a word-array model.
module tb_dmem_responder;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic        rst [2];
  logic        req_valid [2];
  logic [31:0] req_addr [2];
  logic        req_we [2];
  logic [3:0]  req_be [2];
  logic [31:0] req_wdata [2];
  logic        resp_ready [2];
  logic        rdy [2];
  logic        vld [2];
  logic [31:0] rdat [2];
  logic        rerr [2];

  int   hold [2];
  bit   force_rdy [2];
  bit   pend [2];
  exp_t q0 [$];
  exp_t q1 [$];
  logic [31:0] mdl [2][1024];

  dmem_responder_if bus0 ();
  dmem_responder_if bus1 ();

  assign bus0.req_valid  = req_valid[0];
  assign bus0.req_addr   = req_addr[0];
  assign bus0.req_we     = req_we[0];
  assign bus0.req_be     = req_be[0];
  assign bus0.req_wdata  = req_wdata[0];
  assign bus0.resp_ready = resp_ready[0];
  assign rdy[0]  = bus0.req_ready;
  assign vld[0]  = bus0.resp_valid;
  assign rdat[0] = bus0.resp_rdata;
  assign rerr[0] = bus0.resp_err;

  assign bus1.req_valid  = req_valid[1];
  assign bus1.req_addr   = req_addr[1];
  assign bus1.req_we     = req_we[1];
  assign bus1.req_be     = req_be[1];
  assign bus1.req_wdata  = req_wdata[1];
  assign bus1.resp_ready = resp_ready[1];
  assign rdy[1]  = bus1.req_ready;
  assign vld[1]  = bus1.resp_valid;
  assign rdat[1] = bus1.resp_rdata;
  assign rerr[1] = bus1.resp_err;

  dmem_responder #(
    .ADDR_W(10), .WAIT_CYCLES(2),
    .BASE_ADDR(32'h0000_0000)
  ) u_dut0 (
    .clk(clk), .reset(rst[0]), .bus(bus0)
  );

  dmem_responder #(
    .ADDR_W(10), .WAIT_CYCLES(0),
    .BASE_ADDR(32'h0000_1000)
  ) u_dut1 (
    .clk(clk), .reset(rst[1]), .bus(bus1)
  );

  function automatic int wcyc(input int l);
    return (l == 0) ? 2 : 0;
  endfunction

  function automatic logic [31:0] base(input int l);
    return (l == 0) ? 32'h0000_0000 : 32'h0000_1000;
  endfunction

  function automatic int q_size(input int l);
    return (l == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t q_front(input int l);
    return (l == 0) ? q0[0] : q1[0];
  endfunction

  function automatic void q_pop(input int l);
    if (l == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endfunction

  function automatic void q_push(input int l, input exp_t e);
    if (l == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  function automatic void q_clear(input int l);
    if (l == 0) q0.delete();
    else        q1.delete();
  endfunction

  task automatic chk(input string nm, input int l,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s lane%0d t=%0t: got %h want %h",
               nm, l, $time, act, exp);
    end
  endtask

  // Legal iff word aligned and inside [base, base+4KB).
  function automatic bit ref_err(input logic [31:0] a,
                                 input logic [31:0] b);
    longint la, lb;
    la = longint'(a);
    lb = longint'(b);
    return (a % 4 != 0) || (la < lb) || (la >= lb + 4096);
  endfunction

  function automatic exp_t model(input int l,
      input logic [31:0] a, input logic we,
      input logic [3:0] be, input logic [31:0] wd);
    exp_t e;
    int   idx;
    e.err = ref_err(a, base(l));
    e.rdata = 32'h0;
    e.acc = 0;
    if (!e.err) begin
      idx = int'((a - base(l)) / 4);
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) mdl[l][idx][8*i +: 8] = wd[8*i +: 8];
      end else begin
        e.rdata = mdl[l][idx];
      end
    end
    return e;
  endfunction

  task automatic issue(input int l, input logic [31:0] a,
      input logic we, input logic [3:0] be,
      input logic [31:0] wd, output int acc);
    exp_t e;
    int   n;
    @(negedge clk);
    req_valid[l] = 1'b1;
    req_addr[l]  = a;
    req_we[l]    = we;
    req_be[l]    = be;
    req_wdata[l] = wd;
    n = 0;
    while (!rdy[l] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[l]) begin
      chk("accept_timeout", l, 32'(rdy[l]), 32'd1);
      req_valid[l] = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc;
    e = model(l, a, we, be, wd);
    e.acc = acc;
    q_push(l, e);
    @(posedge clk);
    #1;
    req_valid[l] = 1'b0;
    req_addr[l]  = $urandom;
    req_we[l]    = 1'($urandom);
    req_be[l]    = 4'($urandom);
    req_wdata[l] = $urandom;
  endtask

  task automatic do_reset(input int l);
    rst[l] = 1'b1;
    q_clear(l);
    for (int i = 0; i < 1024; i++) mdl[l][i] = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst[l] = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", l, 32'(rdy[l]), 32'd1);
    chk("rst_resp_valid", l, 32'(vld[l]), 32'd0);
    chk("rst_resp_rdata", l, rdat[l], 32'd0);
    chk("rst_resp_err", l, 32'(rerr[l]), 32'd0);
  endtask

  task automatic wait_empty(input int l);
    int n;
    n = 0;
    while (q_size(l) != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (q_size(l) != 0)
      chk("drain_timeout", l, 32'(q_size(l)), 32'd0);
  endtask

  task automatic run_lane(input int l);
    logic [31:0] b;
    logic [31:0] a;
    int acc;
    int accs [4];
    int r;
    b = base(l);
    do_reset(l);
    issue(l, b + 32'h10, 1'b1, 4'hF, 32'hDEADBEEF, acc);
    issue(l, b + 32'h10, 1'b0, 4'h0, 32'h0, acc);
    issue(l, b + 32'h10, 1'b1, 4'b0101, 32'h11223344, acc);
    issue(l, b + 32'h10, 1'b0, 4'hF, 32'h0, acc);
    issue(l, b + 32'h13, 1'b0, 4'hF, 32'h0, acc);
    issue(l, b + 32'h1000, 1'b1, 4'hF, 32'h55AA55AA, acc);
    issue(l, b, 1'b0, 4'h0, 32'h0, acc);
    issue(l, b + 32'h14, 1'b1, 4'hC, 32'hA5A5_0000, acc);
    wait_empty(l);
    hold[l] = 5;
    issue(l, b + 32'h10, 1'b0, 4'h0, 32'h0, acc);
    issue(l, b + 32'h14, 1'b0, 4'h0, 32'h0, acc);
    wait_empty(l);
    issue(l, b + 32'h20, 1'b1, 4'hF, 32'hCAFEF00D, acc);
    do_reset(l);
    issue(l, b + 32'h20, 1'b0, 4'hF, 32'h0, acc);
    wait_empty(l);
    force_rdy[l] = 1'b1;
    for (int k = 0; k < 4; k++)
      issue(l, b + 32'(4 * k), 1'b0, 4'h0, 32'h0, accs[k]);
    wait_empty(l);
    force_rdy[l] = 1'b0;
    for (int k = 1; k < 4; k++)
      chk("throughput", l, 32'(accs[k] - accs[k-1]),
          32'(wcyc(l) + 2));
    for (int k = 0; k < 120; k++) begin
      r = $urandom_range(0, 9);
      if (r <= 6)
        a = b + 32'(4 * $urandom_range(0, 15));
      else if (r == 7)
        a = b + 32'(4 * $urandom_range(1020, 1023));
      else if (r == 8)
        a = b + 32'(4 * $urandom_range(0, 15)
                    + $urandom_range(1, 3));
      else if ($urandom_range(0, 1) == 1)
        a = b + 32'h1000 + 32'(4 * $urandom_range(0, 7));
      else
        a = b - 32'd4;
      issue(l, a, 1'($urandom), 4'($urandom), $urandom, acc);
    end
    wait_empty(l);
  endtask

  // Monitor: owns resp_ready, compares every presented response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
        if (rst[l]) begin
          resp_ready[l] = 1'b0;
          pend[l] = 1'b0;
          chk("req_ready_in_reset", l, 32'(rdy[l]), 32'd0);
        end else if (vld[l]) begin
          chk("req_ready_busy", l, 32'(rdy[l]), 32'd0);
          if (q_size(l) == 0) begin
            chk("resp_without_txn", l, 32'(vld[l]), 32'd0);
            resp_ready[l] = 1'b1;
          end else begin
            e = q_front(l);
            if (!pend[l])
              chk("latency", l, 32'(cyc),
                  32'(e.acc + wcyc(l) + 1));
            pend[l] = 1'b1;
            chk("rdata", l, rdat[l], e.rdata);
            chk("err", l, 32'(rerr[l]), 32'(e.err));
            if (hold[l] > 0) begin
              resp_ready[l] = 1'b0;
              hold[l]--;
            end else if (force_rdy[l]) begin
              resp_ready[l] = 1'b1;
            end else begin
              resp_ready[l] = ($urandom_range(0, 3) != 0);
            end
            if (resp_ready[l]) begin
              q_pop(l);
              pend[l] = 1'b0;
            end
          end
        end else begin
          resp_ready[l] = 1'($urandom);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, checks=%0d",
             checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int l = 0; l < 2; l++) begin
      rst[l] = 1'b1;
      req_valid[l] = 1'b0;
      req_addr[l] = 32'h0;
      req_we[l] = 1'b0;
      req_be[l] = 4'h0;
      req_wdata[l] = 32'h0;
      resp_ready[l] = 1'b0;
      hold[l] = 0;
      force_rdy[l] = 1'b0;
      pend[l] = 1'b0;
    end
    fork
      run_lane(0);
      run_lane(1);
    join
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
